// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, constants and helpers for the UART receive path
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_IDLE
  } uart_rx_state_t;

  // Width of a down-counter that must be able to hold clks_per_bit itself.
  function automatic int uart_timer_width(input int clks_per_bit);
    return $clog2(clks_per_bit + 1);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - loadable bit-period down-counter with expiry flag
module uart_bit_timer #(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  output logic             o_expired
);

  logic [WIDTH-1:0] r_count;

  // Count down to zero and park there; a load always takes priority.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_expired = (r_count == '0);

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver (8E1 when UART_RX_PARITY_EN is defined)
import uart_pkg::*;

module uart_rx #(
  parameter int CLKS_PER_BIT = 104,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      frame_err,
  output logic                      overrun_err,
  output logic                      parity_err
);

  localparam int TW    = uart_timer_width(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [TW-1:0]    HALF_BIT = TW'(CLKS_PER_BIT / 2);
  // Reload one short so that successive expiries are exactly CLKS_PER_BIT apart.
  localparam logic [TW-1:0]    FULL_BIT = TW'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(UART_DATA_BITS - 1);

  logic [SYNC_STAGES-1:0]    r_sync;
  uart_rx_state_t            r_state;
  logic [UART_DATA_BITS-1:0] r_shift;
  logic [UART_DATA_BITS-1:0] r_rx_data;
  logic [IDX_W-1:0]          r_bit_idx;
  logic                      r_rx_valid;
  logic                      r_frame_err;
  logic                      r_overrun_err;
  logic                      w_rx_s;
  logic                      w_expired;
  logic                      w_load;
  logic [TW-1:0]             w_load_val;
  logic                      w_par_ok;

`ifdef UART_RX_PARITY_EN
  logic r_parity_err;
  logic r_par_bad;
  assign w_par_ok   = !r_par_bad;
  assign parity_err = r_parity_err;
`else
  assign w_par_ok   = 1'b1;
  assign parity_err = 1'b0;
`endif

  // Metastability chain; resets to the idle-high line level.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
    end
  end

  assign w_rx_s = r_sync[SYNC_STAGES-1];

  uart_bit_timer #(.WIDTH(TW)) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_load    (w_load),
    .i_load_val(w_load_val),
    .o_expired (w_expired)
  );

  // Timer reloads: half a bit after the start edge, then a full bit per sample point.
  always_comb begin
    w_load     = 1'b0;
    w_load_val = FULL_BIT;
    case (r_state)
      IDLE: begin
        if (!w_rx_s) begin
          w_load     = 1'b1;
          w_load_val = HALF_BIT;
        end
      end
      START:        w_load = w_expired && !w_rx_s;
      DATA, PARITY: w_load = w_expired;
      default:      w_load = 1'b0;
    endcase
  end

  // Frame state machine with registered byte delivery and single-cycle error pulses.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_shift       <= '0;
      r_rx_data     <= '0;
      r_bit_idx     <= '0;
      r_rx_valid    <= 1'b0;
      r_frame_err   <= 1'b0;
      r_overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err  <= 1'b0;
      r_par_bad     <= 1'b0;
`endif
    end else begin
      r_frame_err   <= 1'b0;
      r_overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_parity_err  <= 1'b0;
`endif
      if (r_rx_valid && rx_ready) begin
        r_rx_valid <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (!w_rx_s) begin
            r_state <= START;
          end
        end
        START: begin
          if (w_expired) begin
            if (w_rx_s) begin
              r_state <= IDLE;
            end else begin
              r_bit_idx <= '0;
              r_state   <= DATA;
`ifdef UART_RX_PARITY_EN
              r_par_bad <= 1'b0;
`endif
            end
          end
        end
        DATA: begin
          if (w_expired) begin
            r_shift   <= {w_rx_s, r_shift[UART_DATA_BITS-1:1]};
            r_bit_idx <= r_bit_idx + 1'b1;
            if (r_bit_idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (w_expired) begin
            if (^{r_shift, w_rx_s}) begin
              r_parity_err <= 1'b1;
              r_par_bad    <= 1'b1;
            end
            r_state <= STOP;
          end
        end
`endif
        STOP: begin
          if (w_expired) begin
            if (!w_rx_s) begin
              r_frame_err <= 1'b1;
              r_state     <= WAIT_IDLE;
            end else begin
              r_state <= IDLE;
              if (w_par_ok) begin
                if (!r_rx_valid || rx_ready) begin
                  r_rx_data  <= r_shift;
                  r_rx_valid <= 1'b1;
                end else begin
                  r_overrun_err <= 1'b1;
                end
              end
            end
          end
        end
        WAIT_IDLE: begin
          if (w_rx_s) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign frame_err   = r_frame_err;
  assign overrun_err = r_overrun_err;

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - randomized self-checking bench for uart_rx
module tb_uart_rx;

  localparam int N    = 104;
  localparam int SYNC = 2;
  localparam int DNOM = SYNC + N / 2 + 9 * N;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun_err;
  logic       parity_err;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int valid_cyc, frame_cnt, ovr_cnt, par_cnt, ovr_cyc;
  bit valid_low_seen;
  logic [7:0] acc_q[$];
  logic [7:0] exp_q[$];

  uart_rx #(.CLKS_PER_BIT(N), .SYNC_STAGES(SYNC)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun_err(overrun_err),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observe outputs mid-cycle: record accepted bytes and count pulse cycles.
  always begin
    @(negedge clk);
    #1;
    if (rx_valid) valid_cyc++;
    else valid_low_seen = 1'b1;
    if (rx_valid && rx_ready) acc_q.push_back(rx_data);
    if (frame_err) frame_cnt++;
    if (overrun_err) begin
      ovr_cnt++;
      ovr_cyc = cyc;
    end
    if (parity_err) par_cnt++;
  end

  task automatic clr();
    valid_cyc = 0;
    frame_cnt = 0;
    ovr_cnt = 0;
    par_cnt = 0;
    ovr_cyc = -1;
    valid_low_seen = 1'b0;
    acc_q.delete();
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    hold(1'b0, N);
    for (int i = 0; i < 8; i++) hold(b[i], N);
`ifdef UART_RX_PARITY_EN
    hold(^b, N);
`endif
    hold(stop_bit, N);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", rx_valid); end
    checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", rx_data); end
    checks++; if ({frame_err, overrun_err, parity_err} !== 3'b000) begin failures++; $display("FAIL reset_errs got=%b exp=000", {frame_err, overrun_err, parity_err}); end
    @(negedge clk);
    reset_n = 1'b1;
    hold(1'b1, 4);
  endtask

  task automatic test_single();
    rx_ready = 1'b1;
    clr();
    send_frame(8'hA5, 1'b1);
    hold(1'b1, N);
    checks++; if (acc_q.size() !== 1) begin failures++; $display("FAIL single_count got=%0d exp=1", acc_q.size()); end
    else begin
      checks++; if (acc_q[0] !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", acc_q[0]); end
    end
    checks++; if (valid_cyc !== 1) begin failures++; $display("FAIL single_valid_cycles got=%0d exp=1", valid_cyc); end
    checks++; if (frame_cnt + ovr_cnt + par_cnt !== 0) begin failures++; $display("FAIL single_errs got=%0d exp=0", frame_cnt + ovr_cnt + par_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    rx_ready = 1'b1;
    clr();
    exp_q.delete();
    for (int i = 0; i < 10; i++) begin
      b = 8'($urandom_range(0, 255));
      exp_q.push_back(b);
      send_frame(b, 1'b1);
      hold(1'b1, $urandom_range(0, N));
    end
    hold(1'b1, N);
    checks++; if (acc_q.size() !== exp_q.size()) begin failures++; $display("FAIL b2b_count got=%0d exp=%0d", acc_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < acc_q.size(); i++) begin
      checks++; if (acc_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, acc_q[i], exp_q[i]); end
    end
    checks++; if (frame_cnt + ovr_cnt + par_cnt !== 0) begin failures++; $display("FAIL b2b_errs got=%0d exp=0", frame_cnt + ovr_cnt + par_cnt); end
  endtask

  task automatic test_glitch();
    rx_ready = 1'b1;
    clr();
    hold(1'b0, 20);
    hold(1'b1, 2 * N);
    checks++; if (acc_q.size() !== 0 || valid_cyc !== 0) begin failures++; $display("FAIL glitch_no_valid got=%0d exp=0", valid_cyc); end
    checks++; if (frame_cnt !== 0) begin failures++; $display("FAIL glitch_frame_err got=%0d exp=0", frame_cnt); end
    send_frame(8'h3C, 1'b1);
    hold(1'b1, N);
    checks++; if (acc_q.size() !== 1 || acc_q[0] !== 8'h3C) begin failures++; $display("FAIL glitch_next_byte got=%0d bytes exp=1 byte 3c", acc_q.size()); end
  endtask

  task automatic test_framing();
    rx_ready = 1'b1;
    clr();
    send_frame(8'h55, 1'b0);
    hold(1'b0, 2000);
    hold(1'b1, N);
    checks++; if (frame_cnt !== 1) begin failures++; $display("FAIL frame_err_pulses got=%0d exp=1", frame_cnt); end
    checks++; if (acc_q.size() !== 0) begin failures++; $display("FAIL frame_no_valid got=%0d exp=0", acc_q.size()); end
    send_frame(8'h81, 1'b1);
    hold(1'b1, N);
    checks++; if (acc_q.size() !== 1 || acc_q[0] !== 8'h81) begin failures++; $display("FAIL frame_next_byte got=%0d bytes exp=1 byte 81", acc_q.size()); end
    checks++; if (frame_cnt !== 1) begin failures++; $display("FAIL frame_no_spurious got=%0d exp=1", frame_cnt); end
  endtask

  task automatic test_overrun();
    int c0;
    int d;
    rx_ready = 1'b0;
    clr();
    send_frame(8'h11, 1'b1);
    hold(1'b1, N);
    c0 = cyc;
    send_frame(8'h22, 1'b1);
    hold(1'b1, N);
    d = ovr_cyc - c0;
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h11) begin failures++; $display("FAIL ovr_hold got=%0b/%h exp=1/11", rx_valid, rx_data); end
    checks++; if (ovr_cnt !== 1) begin failures++; $display("FAIL ovr_pulses got=%0d exp=1", ovr_cnt); end
    checks++; if (d < DNOM - 4 || d > DNOM + 4) begin failures++; $display("FAIL ovr_latency got=%0d exp=%0d+-4", d, DNOM); d = DNOM; end
    clr();
    fork
      send_frame(8'h33, 1'b1);
      begin
        repeat (d - 1) @(negedge clk);
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
      end
    join
    hold(1'b1, N);
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h33) begin failures++; $display("FAIL same_cycle_data got=%0b/%h exp=1/33", rx_valid, rx_data); end
    checks++; if (ovr_cnt !== 0) begin failures++; $display("FAIL same_cycle_overrun got=%0d exp=0", ovr_cnt); end
    checks++; if (valid_low_seen !== 1'b0) begin failures++; $display("FAIL same_cycle_valid_dropped got=%0b exp=0", valid_low_seen); end
    checks++; if (acc_q.size() !== 1 || acc_q[0] !== 8'h11) begin failures++; $display("FAIL same_cycle_accept got=%0d bytes exp=1 byte 11", acc_q.size()); end
    rx_ready = 1'b1;
    hold(1'b1, 4);
  endtask

  task automatic test_reset_midframe();
    logic [7:0] b;
    b = 8'hF0;
    rx_ready = 1'b0;
    clr();
    send_frame(8'h5A, 1'b1);
    hold(1'b1, N);
    checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h5A) begin failures++; $display("FAIL pre_reset_pending got=%0b/%h exp=1/5a", rx_valid, rx_data); end
    hold(1'b0, N);
    for (int i = 0; i < 4; i++) hold(b[i], N);
    hold(b[4], N / 2);
    reset_n = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (rx_valid !== 1'b0 || rx_data !== 8'h00) begin failures++; $display("FAIL midreset_out got=%0b/%h exp=0/00", rx_valid, rx_data); end
    checks++; if ({frame_err, overrun_err, parity_err} !== 3'b000) begin failures++; $display("FAIL midreset_errs got=%b exp=000", {frame_err, overrun_err, parity_err}); end
    reset_n = 1'b1;
    rx_ready = 1'b1;
    clr();
    hold(1'b1, 2 * N);
    send_frame(8'h0F, 1'b1);
    hold(1'b1, N);
    checks++; if (acc_q.size() !== 1 || acc_q[0] !== 8'h0F) begin failures++; $display("FAIL midreset_next got=%0d bytes exp=1 byte 0f", acc_q.size()); end
    checks++; if (frame_cnt + ovr_cnt + par_cnt !== 0) begin failures++; $display("FAIL midreset_next_errs got=%0d exp=0", frame_cnt + ovr_cnt + par_cnt); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    logic [7:0] b;
    b = 8'h07;
    rx_ready = 1'b1;
    clr();
    hold(1'b0, N);
    for (int i = 0; i < 8; i++) hold(b[i], N);
    hold(~(^b), N);
    hold(1'b1, N);
    hold(1'b1, N);
    checks++; if (par_cnt !== 1) begin failures++; $display("FAIL parity_pulses got=%0d exp=1", par_cnt); end
    checks++; if (acc_q.size() !== 0) begin failures++; $display("FAIL parity_discard got=%0d exp=0", acc_q.size()); end
    checks++; if (frame_cnt !== 0) begin failures++; $display("FAIL parity_frame got=%0d exp=0", frame_cnt); end
    clr();
    send_frame(b, 1'b1);
    hold(1'b1, N);
    checks++; if (acc_q.size() !== 1 || acc_q[0] !== 8'h07) begin failures++; $display("FAIL parity_good got=%0d bytes exp=1 byte 07", acc_q.size()); end
    checks++; if (par_cnt !== 0) begin failures++; $display("FAIL parity_good_err got=%0d exp=0", par_cnt); end
  endtask
`endif

  initial begin
    clr();
    @(negedge clk);
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_overrun();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
